vector_op_sequencer: RTL

//  Sequences read-out of vector BRAMs A and B once commandDecoder issues an operation.

---
 rtl/vector_op_sequencer_pkg.sv | 26 ++
 rtl/vector_op_sequencer_if.sv | 24 ++
 rtl/vector_op_sequencer_fifo.sv | 69 ++++++
 rtl/vector_op_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vector_op_sequencer_pkg.sv
// Shared types for the vector op sequencer: command codes and sequencer FSM states.
// No logic, so no latency.
// No handshake, so no backpressure.
package vec_pkg;

    // Command issued by the command decoder. CMD_NONE never starts a sweep.
    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_READ_A = 3'd1,
        CMD_READ_B = 3'd2,
        CMD_SUM    = 3'd3,
        CMD_AVG    = 3'd4,
        CMD_MAN    = 3'd5,
        CMD_EUC    = 3'd6,
        CMD_DOT    = 3'd7
    } cmd_t;

    // Sweep sequencer states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/vector_op_sequencer_if.sv
// Element-pair stream from the sequencer to the operation datapath.
// Wires only, so no latency.
// Transfer when elem_valid & elem_ready; the master holds the payload while stalled.
interface vector_op_sequencer_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10
);
    logic              elem_valid;
    logic              elem_ready;
    logic [DATA_W-1:0] elem_a;
    logic [DATA_W-1:0] elem_b;
    logic [ADDR_W-1:0] elem_idx;
    logic              elem_last;

    modport master (
        output elem_valid, elem_a, elem_b, elem_idx, elem_last,
        input  elem_ready
    );

    modport slave (
        input  elem_valid, elem_a, elem_b, elem_idx, elem_last,
        output elem_ready
    );
endinterface

// File: rtl/vector_op_sequencer_fifo.sv
// Small synchronous FIFO with fall-through output (head entry visible while not empty).
// Latency: a push is visible at the output the cycle after it is written.
// Backpressure: pushes are dropped when full with no pop; the caller's credit scheme prevents that.
module seq_skid_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,      // synchronous, active-low
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    logic             w_full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_pop     = i_pop && !o_empty;
    // A pop frees the head slot in the same cycle, so a push into a full FIFO is safe then.
    assign w_push    = i_push && (!w_full || w_pop);
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage write; contents need no reset because occupancy is tracked by r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
    always_ff @(posedge i_clk) begin
        if (!i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vector_op_sequencer.sv
// Sweeps BRAM A/B read addresses 0..N_ELEMS-1 and streams element pairs to the datapath.
// Latency: start in cycle 0, first elem_valid in cycle BRAM_LAT+2, op_done N_ELEMS+BRAM_LAT+3 at full rate.
// Backpressure: reads are issued only while FIFO occupancy plus in-flight reads leave room.
module vector_op_sequencer
    import vec_pkg::*;
#(
    parameter int N_ELEMS  = 1024,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 10,
    parameter int BRAM_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,            // synchronous, active-low
    input  logic              i_start,
    input  cmd_t              i_command,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_bram_a_read_addr,
    output logic [ADDR_W-1:0] o_bram_b_read_addr,
    input  logic [DATA_W-1:0] i_bram_a_dout,
    input  logic [DATA_W-1:0] i_bram_b_dout,
    vector_op_sequencer_if.master elem_if,
    output cmd_t              o_op_code,
    output logic              o_busy,
    output logic              o_op_done
);

    // FIFO must cover every read that can be in flight plus slack for a full-rate stream.
    localparam int FIFO_DEPTH = BRAM_LAT + 2;
    localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W      = $clog2(2 * FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ELEMS - 1);

    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } elem_t;

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    cmd_t              r_op_code;
    logic [BRAM_LAT-1:0] r_sr_vld;
    logic [ADDR_W-1:0] r_sr_idx [BRAM_LAT];

    logic              w_accept_start;
    logic              w_issue;
    logic              w_flush;
    logic              w_credit_ok;
    logic [OUT_W-1:0]  w_inflight;
    logic [OUT_W-1:0]  w_outstanding;
    logic [FCNT_W-1:0] w_fifo_count;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_tap_vld;
    logic [ADDR_W-1:0] w_tap_idx;
    elem_t             w_push_dat;
    elem_t             w_pop_dat;

    assign w_tap_vld = r_sr_vld[BRAM_LAT-1];
    assign w_tap_idx = r_sr_idx[BRAM_LAT-1];

    // Count reads issued to the BRAMs whose data has not yet landed in the FIFO.
    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < BRAM_LAT; k++) begin
            w_inflight = w_inflight + OUT_W'(r_sr_vld[k]);
        end
    end

    // Same-cycle pops are deliberately not credited, keeping the check off the ready path.
    assign w_outstanding = OUT_W'(w_fifo_count) + w_inflight;
    assign w_credit_ok   = (w_outstanding < OUT_W'(FIFO_DEPTH));

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode: start acceptance, read issue, abort flush, done pulse.
    always_comb begin
        w_state_nxt    = r_state;
        w_accept_start = 1'b0;
        w_issue        = 1'b0;
        w_flush        = 1'b0;
        o_op_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && (i_command != CMD_NONE)) begin
                    w_accept_start = 1'b1;
                    w_state_nxt    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_abort) begin
                    w_flush     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (r_addr == LAST_IDX) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (i_abort) begin
                    w_flush     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if ((w_inflight == '0) && w_fifo_empty) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_op_done   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Read address and latched command; the address parks on the last index after a sweep.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_addr    <= '0;
            r_op_code <= CMD_NONE;
        end else if (w_accept_start) begin
            r_addr    <= '0;
            r_op_code <= i_command;
        end else if (w_issue && (r_addr != LAST_IDX)) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    // Valid tags for reads in flight through the BRAM pipeline; dropped on abort.
    always_ff @(posedge i_clk) begin
        if (!i_reset || w_flush) begin
            r_sr_vld <= '0;
        end else begin
            r_sr_vld[0] <= w_issue;
            for (int k = 1; k < BRAM_LAT; k++) begin
                r_sr_vld[k] <= r_sr_vld[k-1];
            end
        end
    end

    // Element index travelling alongside each in-flight read; only meaningful when tagged valid.
    always_ff @(posedge i_clk) begin
        r_sr_idx[0] <= r_addr;
        for (int k = 1; k < BRAM_LAT; k++) begin
            r_sr_idx[k] <= r_sr_idx[k-1];
        end
    end

    // Single-vector reads zero the unused operand before it enters the FIFO.
    always_comb begin
        w_push_dat      = '0;
        w_push_dat.last = (w_tap_idx == LAST_IDX);
        w_push_dat.idx  = w_tap_idx;
        w_push_dat.a    = (r_op_code == CMD_READ_B) ? '0 : i_bram_a_dout;
        w_push_dat.b    = (r_op_code == CMD_READ_A) ? '0 : i_bram_b_dout;
    end

    assign w_pop = !w_fifo_empty && elem_if.elem_ready;

    seq_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(elem_t))
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_flush    (w_flush),
        .i_push     (w_tap_vld),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_pop_dat  (w_pop_dat),
        .o_count    (w_fifo_count),
        .o_empty    (w_fifo_empty)
    );

    assign elem_if.elem_valid = !w_fifo_empty;
    assign elem_if.elem_a     = w_pop_dat.a;
    assign elem_if.elem_b     = w_pop_dat.b;
    assign elem_if.elem_idx   = w_pop_dat.idx;
    assign elem_if.elem_last  = w_pop_dat.last;

    assign o_bram_a_read_addr = r_addr;
    assign o_bram_b_read_addr = r_addr;
    assign o_op_code          = r_op_code;
    assign o_busy             = (r_state != S_IDLE);

endmodule
